// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - state_t      : responder FSM states (ST_INIT clears the array, ST_READY serves)
//   - MASK_*       : byte-lane write masks the core is allowed to issue
//   - ERR_CNT_MAX  : saturation value of the illegal-write counter
//   - mask_legal() : 1 when a write mask is one of the legal lane patterns
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Byte, aligned half-word and full-word lane patterns only.
    function automatic logic mask_legal(input logic [3:0] mask);
        case (mask)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3,
            MASK_H0, MASK_H1, MASK_W: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Core-side data-memory bus.
//   dmaddr_in    : byte address, driven every cycle (also the read address)
//   dmdata_in    : lane-aligned write data
//   dmwr_mask_in : byte-lane write enables, bit i = byte i
//   dmwr_req_in  : write request
//   dmdata_out   : registered read data, valid one cycle after the address
// Handshake: dmwr_req_in qualifies a write for exactly the cycle it is high;
// there is no ready/backpressure, so every request is consumed in the cycle it
// is presented (dropped while the array is still being cleared). The mask is
// ignored whenever dmwr_req_in is low.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic [31:0] dmaddr_in;
    logic [31:0] dmdata_in;
    logic [3:0]  dmwr_mask_in;
    logic        dmwr_req_in;
    logic [31:0] dmdata_out;

    modport master (
        output dmaddr_in, dmdata_in, dmwr_mask_in, dmwr_req_in,
        input  dmdata_out
    );

    modport slave (
        input  dmaddr_in, dmdata_in, dmwr_mask_in, dmwr_req_in,
        output dmdata_out
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// -----------------------------------------------------------------------------
// dmem_byte_ram
// DEPTH x 32-bit array organised as four byte lanes, one write port with
// per-lane enables and one registered read port. A read and a write to the
// same word in one cycle return the old contents.
//   clk_in  : clock
//   i_we    : per-lane write enables
//   i_waddr : write word index
//   i_wdata : write data (lane i = bits 8i+7:8i)
//   i_raddr : read word index
//   o_rdata : read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module dmem_byte_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_in,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [3:0][7:0] r_mem [DEPTH];
    logic [31:0]     r_rdata;

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][i] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder behind the core's data port. After reset it walks the
// array writing zeros (ST_INIT, DEPTH cycles), then serves byte-masked writes
// and one-cycle-latency reads (ST_READY). Illegal writes (out of range or a
// non-aligned lane pattern) are dropped and counted.
// Optional build macro: DMEM_WR_FWD_EN -- a legal write returns the merged word
// on the same-cycle read instead of the old contents.
// Ports:
//   clk_in        : clock, rising edge
//   rst_in        : asynchronous active-low reset
//   dm_if         : core data bus (slave side)
//   err_clr_in    : synchronous clear of err_out / err_cnt_out (wins over a new error)
//   mem_ready_out : 1 once the post-reset clear has completed
//   err_out       : sticky illegal-write flag
//   err_cnt_out   : saturating illegal-write count
//   dbg_state_out : current FSM state
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    dmem_responder_if.slave   dm_if,
    input  logic              err_clr_in,
    output logic              mem_ready_out,
    output logic              err_out,
    output logic [7:0]        err_cnt_out,
    output state_t            dbg_state_out
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic [31:0]       w_off;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused_lo;
    logic              w_ready;
    logic              w_wr_legal;
    logic              w_wr_illegal;

    logic [3:0]        w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_ram_rdata;

    logic              r_rd_valid;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
    assign w_off       = dm_if.dmaddr_in - BASE_ADDR;
    assign w_in_range  = (w_off[31:ADDR_W+2] == '0);
    assign w_idx       = w_off[ADDR_W+1:2];
    assign w_unused_lo = &{1'b0, w_off[1:0]};

    assign w_ready      = (r_state == ST_READY);
    assign w_wr_legal   = w_ready && dm_if.dmwr_req_in && w_in_range &&
                          mask_legal(dm_if.dmwr_mask_in);
    assign w_wr_illegal = w_ready && dm_if.dmwr_req_in && !w_wr_legal;

    // FSM state register and clear counter
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Next state and RAM write-port steering
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 4'b0000;
        w_ram_waddr = w_idx;
        w_ram_wdata = dm_if.dmdata_in;
        case (r_state)
            ST_INIT: begin
                w_ram_we    = 4'b1111;
                w_ram_waddr = r_clr_cnt;
                w_ram_wdata = 32'h0;
                if (r_clr_cnt == '1) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (w_wr_legal) begin
                    w_ram_we = dm_if.dmwr_mask_in;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    dmem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_in  (clk_in),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rdata)
    );

    // Reads outside READY or outside the window return zero.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_ready && w_in_range;
        end
    end

`ifdef DMEM_WR_FWD_EN
    // Read and write always share one address, so any legal write hits the
    // word being read; remember which lanes to take from the write data.
    logic [3:0]  r_fwd_mask;
    logic [31:0] r_fwd_data;
    logic [31:0] w_rd_merged;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_fwd_mask <= 4'b0000;
            r_fwd_data <= 32'h0;
        end else begin
            r_fwd_mask <= w_wr_legal ? dm_if.dmwr_mask_in : 4'b0000;
            r_fwd_data <= dm_if.dmdata_in;
        end
    end

    always_comb begin
        w_rd_merged = w_ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_fwd_mask[i]) begin
                w_rd_merged[8*i +: 8] = r_fwd_data[8*i +: 8];
            end
        end
    end

    assign dm_if.dmdata_out = r_rd_valid ? w_rd_merged : 32'h0;
`else
    assign dm_if.dmdata_out = r_rd_valid ? w_ram_rdata : 32'h0;
`endif

    // Error flag and saturating counter; a clear beats a same-cycle error.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else if (err_clr_in) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else if (w_wr_illegal) begin
            r_err <= 1'b1;
            if (r_err_cnt != ERR_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
        end
    end

    assign mem_ready_out = w_ready;
    assign err_out       = r_err;
    assign err_cnt_out   = r_err_cnt;
    assign dbg_state_out = r_state;
endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Exercises dmem_responder (ADDR_W=4, BASE_ADDR=0x1000) against a word-array
// reference model: clear sequence, byte-lane merges, illegal writes and error
// saturation, address window edges, same-cycle read/write, random traffic and
// reset during the clear. Honours DMEM_WR_FWD_EN for the same-cycle read value.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int          ADDR_W = 4;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic       clk_in     = 1'b0;
    logic       rst_in     = 1'b0;
    logic       err_clr_in = 1'b0;
    logic       mem_ready_out;
    logic       err_out;
    logic [7:0] err_cnt_out;
    state_t     dbg_state_out;

    dmem_responder_if dm_if ();

    dmem_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .dm_if         (dm_if),
        .err_clr_in    (err_clr_in),
        .mem_ready_out (mem_ready_out),
        .err_out       (err_out),
        .err_cnt_out   (err_cnt_out),
        .dbg_state_out (dbg_state_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: plain word array plus error state.
    logic [31:0] mem_m [DEPTH];
    logic        err_m;
    logic [7:0]  cnt_m;

    function automatic bit ref_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'(4 * DEPTH);
    endfunction

    function automatic bit ref_legal(input logic [3:0] mask);
        return mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0011, 4'b1100, 4'b1111};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        err_m = 1'b0;
        cnt_m = 8'h00;
    endtask

    // One READY cycle: drive inputs, predict, clock, compare.
    task automatic step(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input bit req, input bit clr,
                        input string tag);
        logic [31:0] exp_rd, old_w, new_w;
        int          idx;
        bit          in_rng, legal;
        dm_if.dmaddr_in    = addr;
        dm_if.dmdata_in    = data;
        dm_if.dmwr_mask_in = mask;
        dm_if.dmwr_req_in  = req;
        err_clr_in         = clr;

        in_rng = ref_in_range(addr);
        idx    = in_rng ? int'((addr - BASE) / 4) : 0;
        old_w  = mem_m[idx];
        exp_rd = in_rng ? old_w : 32'h0;
        legal  = req && in_rng && ref_legal(mask);
        if (legal) begin
            new_w = old_w;
            for (int i = 0; i < 4; i++)
                if (mask[i]) new_w[8*i +: 8] = data[8*i +: 8];
            mem_m[idx] = new_w;
`ifdef DMEM_WR_FWD_EN
            exp_rd = new_w;
`endif
        end
        if (clr) begin
            err_m = 1'b0;
            cnt_m = 8'h00;
        end else if (req && !legal) begin
            err_m = 1'b1;
            cnt_m = (cnt_m == 8'hFF) ? 8'hFF : cnt_m + 8'h01;
        end

        @(posedge clk_in); #1;
        n_vec++;
        if (dm_if.dmdata_out !== exp_rd) begin
            n_miss++;
            $display("FAIL %s rdata @%h: got %h expected %h", tag, addr, dm_if.dmdata_out, exp_rd);
        end
        n_vec++;
        if (err_out !== err_m) begin
            n_miss++;
            $display("FAIL %s err_out: got %b expected %b", tag, err_out, err_m);
        end
        n_vec++;
        if (err_cnt_out !== cnt_m) begin
            n_miss++;
            $display("FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt_out, cnt_m);
        end
    endtask

    // Counts cycles from reset release until mem_ready_out, checking that reads
    // stay zero and the error counter stays clear throughout the clear sequence.
    task automatic wait_ready(input int exp_cycles, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
            n_vec++;
            if (dm_if.dmdata_out !== 32'h0 || err_cnt_out !== 8'h00) begin
                n_miss++;
                $display("FAIL %s init outputs cycle %0d: rdata %h cnt %0d expected 0 and 0",
                         tag, n, dm_if.dmdata_out, err_cnt_out);
            end
        end while (!mem_ready_out && n < 100);
        dm_if.dmwr_req_in = 1'b0;
        n_vec++;
        if (!mem_ready_out || n != exp_cycles) begin
            n_miss++;
            $display("FAIL %s ready latency: got %0d cycles (ready=%b) expected %0d",
                     tag, n, mem_ready_out, exp_cycles);
        end
    endtask

    task automatic idle_inputs();
        dm_if.dmaddr_in    = BASE;
        dm_if.dmdata_in    = 32'h0;
        dm_if.dmwr_mask_in = 4'b0000;
        dm_if.dmwr_req_in  = 1'b0;
        err_clr_in         = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        model_reset();
        for (int i = 0; i < DEPTH; i++)
            step(BASE + 32'(4 * i), $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0, tag);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        #23;
        n_vec++;
        if (mem_ready_out !== 1'b0 || err_out !== 1'b0 || err_cnt_out !== 8'h00 ||
            dm_if.dmdata_out !== 32'h0 || dbg_state_out !== ST_INIT) begin
            n_miss++;
            $display("FAIL reset_values: ready %b err %b cnt %0d rdata %h state %0d expected all zero",
                     mem_ready_out, err_out, err_cnt_out, dm_if.dmdata_out, dbg_state_out);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        wait_ready(DEPTH, "reset_init");
        n_vec++;
        if (dbg_state_out !== ST_READY) begin
            n_miss++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state_out, ST_READY);
        end
        read_all_zero("reset_readback");
    endtask

    task automatic test_lane_merge();
        step(BASE + 32'h8, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, "merge_w");
        step(BASE + 32'h8, 32'h0000AA00, 4'b0010, 1'b1, 1'b0, "merge_b1");
        step(BASE + 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, "merge_rd");
        n_vec++;
        if (dm_if.dmdata_out !== 32'hDEADAAEF) begin
            n_miss++;
            $display("FAIL merge_value: got %h expected DEADAAEF", dm_if.dmdata_out);
        end
        step(BASE + 32'hB, 32'h0, 4'b0000, 1'b0, 1'b0, "merge_rd_lowbits");
        step(BASE + 32'h8, 32'h5566_0000, 4'b1100, 1'b1, 1'b0, "merge_h1");
        step(BASE + 32'h8, 32'h0000_0077, 4'b0001, 1'b1, 1'b0, "merge_b0");
        step(BASE + 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, "merge_rd2");
    endtask

    task automatic test_illegal();
        step(BASE + 32'h4, 32'h12345678, 4'b0101, 1'b1, 1'b0, "illegal_first");
        n_vec++;
        if (err_out !== 1'b1 || err_cnt_out !== 8'd1) begin
            n_miss++;
            $display("FAIL illegal_first_cnt: err %b cnt %0d expected 1 and 1", err_out, err_cnt_out);
        end
        for (int i = 0; i < 299; i++)
            step(BASE + 32'h4, 32'h12345678, 4'b0101, 1'b1, 1'b0, "illegal_repeat");
        n_vec++;
        if (err_cnt_out !== 8'hFF) begin
            n_miss++;
            $display("FAIL illegal_saturate: got %h expected FF", err_cnt_out);
        end
        step(BASE + 32'h4, 32'h0, 4'b0000, 1'b0, 1'b0, "illegal_word_untouched");
        step(BASE + 32'h4, 32'h0, 4'b0000, 1'b0, 1'b1, "illegal_clear");
        step(BASE + 32'h4, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, "illegal_mask0");
        step(BASE + 32'h4, 32'hFFFFFFFF, 4'b0110, 1'b1, 1'b1, "clear_wins");
        n_vec++;
        if (err_out !== 1'b0 || err_cnt_out !== 8'h00) begin
            n_miss++;
            $display("FAIL clear_wins_value: err %b cnt %0d expected 0 and 0", err_out, err_cnt_out);
        end
    endtask

    task automatic test_range();
        step(BASE, 32'h0, 4'b0000, 1'b0, 1'b1, "range_clr");
        step(32'h0000_0FFC, 32'hAAAAAAAA, 4'b1111, 1'b1, 1'b0, "range_below");
        step(32'h0000_1040, 32'hBBBBBBBB, 4'b1111, 1'b1, 1'b0, "range_above");
        n_vec++;
        if (err_cnt_out !== 8'd2) begin
            n_miss++;
            $display("FAIL range_cnt: got %0d expected 2", err_cnt_out);
        end
        step(32'h0000_1040, 32'h0, 4'b0000, 1'b0, 1'b0, "range_read_above");
        step(32'h0000_0000, 32'h0, 4'b0000, 1'b0, 1'b0, "range_read_alias");
        step(32'h0000_103C, 32'hC0DE_0001, 4'b1111, 1'b1, 1'b0, "range_last_word");
        step(32'h0000_103C, 32'h0, 4'b0000, 1'b0, 1'b0, "range_last_read");
        step(BASE, 32'h0, 4'b0000, 1'b0, 1'b0, "range_first_read");
    endtask

    task automatic test_same_cycle();
        step(BASE, 32'h11111111, 4'b1111, 1'b1, 1'b0, "same_pre");
        step(BASE, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, "same_rw");
        n_vec++;
`ifdef DMEM_WR_FWD_EN
        if (dm_if.dmdata_out !== 32'hCAFEF00D) begin
            n_miss++;
            $display("FAIL same_rw_value: got %h expected CAFEF00D", dm_if.dmdata_out);
        end
`else
        if (dm_if.dmdata_out !== 32'h11111111) begin
            n_miss++;
            $display("FAIL same_rw_value: got %h expected 11111111", dm_if.dmdata_out);
        end
`endif
        step(BASE, 32'h0000_BEEF, 4'b0011, 1'b1, 1'b0, "same_rw_half");
        step(BASE, 32'h0, 4'b0000, 1'b0, 1'b0, "same_after");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 300; i++) begin
            addr = BASE - 32'd8 + 32'(4 * $urandom_range(0, 19)) + 32'($urandom_range(0, 3));
            step(addr, $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), "random");
        end
    endtask

    task automatic test_reset_mid_init();
        idle_inputs();
        rst_in = 1'b0;
        #12;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        repeat (7) @(posedge clk_in);
        #1;
        n_vec++;
        if (dbg_state_out !== ST_INIT || mem_ready_out !== 1'b0) begin
            n_miss++;
            $display("FAIL midinit_state: state %0d ready %b expected INIT and 0", dbg_state_out, mem_ready_out);
        end
        rst_in = 1'b0;
        #3;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        // Write attempt while the array is still being cleared.
        dm_if.dmaddr_in    = BASE + 32'h8;
        dm_if.dmdata_in    = 32'hFFFF_FFFF;
        dm_if.dmwr_mask_in = 4'b1111;
        dm_if.dmwr_req_in  = 1'b1;
        wait_ready(DEPTH, "midinit");
        read_all_zero("midinit_readback");
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_lane_merge();
        test_illegal();
        test_range();
        test_same_cycle();
        test_random();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
